// File: rtl/spi_sensor_seq.sv
// Sequences an SPI sensor: waits out power-up, sends two config writes, then
// reads a high/low byte pair per data-ready interrupt and presents the 16-bit result.
//
// state  | meaning
// PWR_WT | counting the power-up delay
// CFG0   | issuing first config write (wrt high)
// CFG0_W | waiting for first config write to finish
// CFG1   | issuing second config write (wrt high)
// CFG1_W | waiting for second config write to finish
// IDLE   | configured, waiting for a pending interrupt
// RDHI   | issuing high-byte read (wrt high)
// RDHI_W | waiting for high-byte read data
// RDLO   | issuing low-byte read (wrt high)
// RDLO_W | waiting for low-byte read data
module spi_sensor_seq #(
    parameter logic [15:0] INIT_WAIT = 16'd1024,
    parameter logic [15:0] CFG0_CMD  = 16'h0D02,
    parameter logic [15:0] CFG1_CMD  = 16'h1160,
    parameter logic [15:0] RDHI_CMD  = 16'hA300,
    parameter logic [15:0] RDLO_CMD  = 16'hA200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        cfg_rdy,
    output logic [15:0] meas,
    output logic        vld
);

    typedef enum logic [3:0] {
        PWR_WT, CFG0, CFG0_W, CFG1, CFG1_W, IDLE, RDHI, RDHI_W, RDLO, RDLO_W
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic        int_s1, int_s2, int_s3;
    logic        int_pend;
    logic        int_rise;
    logic [7:0]  hi;
    logic        unused_rd_hi;

    assign int_rise     = int_s2 & ~int_s3;
    assign unused_rd_hi = ^rd_data[15:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_s1 <= 1'b0;
            int_s2 <= 1'b0;
            int_s3 <= 1'b0;
        end else begin
            int_s1 <= INT;
            int_s2 <= int_s1;
            int_s3 <= int_s2;
        end
    end

    // A rise coinciding with the RDHI issue cycle must not be lost, so set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            int_pend <= 1'b0;
        else if (int_rise)
            int_pend <= 1'b1;
        else if (state == RDHI)
            int_pend <= 1'b0;
    end

    // wrt/cmd are loaded on entry to an issue state so they are high during it;
    // the issue state itself never looks at done, which may still be stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PWR_WT;
            cnt     <= 16'd0;
            wrt     <= 1'b0;
            cmd     <= 16'h0000;
            cfg_rdy <= 1'b0;
            meas    <= 16'h0000;
            vld     <= 1'b0;
            hi      <= 8'h00;
        end else begin
            wrt <= 1'b0;
            vld <= 1'b0;
            case (state)
                PWR_WT: begin
                    if (cnt == INIT_WAIT - 16'd1) begin
                        state <= CFG0;
                        wrt   <= 1'b1;
                        cmd   <= CFG0_CMD;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                CFG0: state <= CFG0_W;
                CFG0_W: begin
                    if (done) begin
                        state <= CFG1;
                        wrt   <= 1'b1;
                        cmd   <= CFG1_CMD;
                    end
                end
                CFG1: state <= CFG1_W;
                CFG1_W: begin
                    if (done) begin
                        state   <= IDLE;
                        cfg_rdy <= 1'b1;
                    end
                end
                IDLE: begin
                    if (int_pend) begin
                        state <= RDHI;
                        wrt   <= 1'b1;
                        cmd   <= RDHI_CMD;
                    end
                end
                RDHI: state <= RDHI_W;
                RDHI_W: begin
                    if (done) begin
                        hi    <= rd_data[7:0];
                        state <= RDLO;
                        wrt   <= 1'b1;
                        cmd   <= RDLO_CMD;
                    end
                end
                RDLO: state <= RDLO_W;
                RDLO_W: begin
                    if (done) begin
                        meas  <= {hi, rd_data[7:0]};
                        vld   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= PWR_WT;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sensor_seq.sv
// Bench for spi_sensor_seq: a behavioural SPI monarch with random read bytes,
// a transaction log and an expected-measurement queue built from the responses it gives.
module tb_spi_sensor_seq;

    localparam logic [15:0] C_CFG0 = 16'h0D02;
    localparam logic [15:0] C_CFG1 = 16'h1160;
    localparam logic [15:0] C_RDHI = 16'hA300;
    localparam logic [15:0] C_RDLO = 16'hA200;
    localparam int BUSY = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        done = 1'b1;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt;
    logic [15:0] cmd;
    logic        cfg_rdy;
    logic [15:0] meas;
    logic        vld;

    always #5 clk = ~clk;

    spi_sensor_seq #(.INIT_WAIT(16'd8)) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .wrt(wrt), .cmd(cmd), .done(done),
        .rd_data(rd_data), .cfg_rdy(cfg_rdy), .meas(meas), .vld(vld)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel_cyc = 0;
    int cfg_rdy_cyc = -1;
    int proto_err = 0;

    logic [15:0] wrt_cmd_q[$];
    int          wrt_cyc_q[$];
    logic [15:0] vld_meas_q[$];
    int          vld_cyc_q[$];
    logic [15:0] exp_meas_q[$];
    int          done_cyc_q[$];

    int          busy_cnt = 0;
    logic [15:0] cur_cmd = 16'h0000;
    logic [7:0]  resp_byte = 8'h00;
    logic [7:0]  last_hi = 8'h00;
    bit          force_en = 0;
    logic [7:0]  force_hi = 8'h00;
    logic [7:0]  force_lo = 8'h00;
    logic        prev_wrt = 1'b0;
    logic        prev_vld = 1'b0;
    logic        prev_cfg = 1'b0;

    function automatic logic [15:0] at16(input logic [15:0] q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : 16'hxxxx;
    endfunction

    function automatic int ati(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -99999;
    endfunction

    // Monarch model plus logger: done drops one cycle after wrt, rises BUSY cycles after it.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst_n) begin
            busy_cnt = 0;
            done     = 1'b1;
            prev_wrt = 1'b0;
            prev_vld = 1'b0;
            prev_cfg = 1'b0;
        end else begin
            if (busy_cnt > 0) begin
                if (cmd !== cur_cmd) proto_err++;
                busy_cnt--;
                if (busy_cnt == 0) begin
                    done = 1'b1;
                    done_cyc_q.push_back(cyc);
                    if (cur_cmd[15]) rd_data = {8'($urandom), resp_byte};
                end else begin
                    done = 1'b0;
                end
            end
            if (wrt === 1'b1) begin
                if (busy_cnt > 0 || prev_wrt) proto_err++;
                wrt_cmd_q.push_back(cmd);
                wrt_cyc_q.push_back(cyc);
                cur_cmd  = cmd;
                busy_cnt = BUSY;
                if (cmd == C_RDHI) begin
                    resp_byte = force_en ? force_hi : 8'($urandom);
                    last_hi   = resp_byte;
                end else if (cmd == C_RDLO) begin
                    resp_byte = force_en ? force_lo : 8'($urandom);
                    exp_meas_q.push_back({last_hi, resp_byte});
                end
            end
            if (vld === 1'b1) begin
                if (prev_vld) proto_err++;
                vld_meas_q.push_back(meas);
                vld_cyc_q.push_back(cyc);
            end
            if (cfg_rdy === 1'b1 && !prev_cfg) cfg_rdy_cyc = cyc;
            prev_wrt = wrt;
            prev_vld = vld;
            prev_cfg = cfg_rdy;
        end
    end

    task automatic pulse_int();
        @(negedge clk);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        INT   = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (wrt !== 1'b0) begin errors++; $display("FAIL reset_wrt: got %b exp 0", wrt); end
        checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL reset_cmd: got %h exp 0000", cmd); end
        checks++; if (cfg_rdy !== 1'b0) begin errors++; $display("FAIL reset_cfg_rdy: got %b exp 0", cfg_rdy); end
        checks++; if (meas !== 16'h0000) begin errors++; $display("FAIL reset_meas: got %h exp 0000", meas); end
        checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b exp 0", vld); end
        rst_n   = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic test_config();
        for (int i = 0; i < 400 && cfg_rdy !== 1'b1; i++) @(negedge clk);
        checks++; if (cfg_rdy !== 1'b1) begin errors++; $display("FAIL cfg_timeout: cfg_rdy got %b exp 1", cfg_rdy); end
        checks++; if (wrt_cmd_q.size() !== 2) begin errors++; $display("FAIL cfg_wrt_count: got %0d exp 2", wrt_cmd_q.size()); end
        checks++; if (at16(wrt_cmd_q, 0) !== C_CFG0) begin errors++; $display("FAIL cfg0_cmd: got %h exp %h", at16(wrt_cmd_q, 0), C_CFG0); end
        checks++; if (ati(wrt_cyc_q, 0) - rel_cyc !== 8) begin errors++; $display("FAIL cfg0_delay: got %0d exp 8", ati(wrt_cyc_q, 0) - rel_cyc); end
        checks++; if (at16(wrt_cmd_q, 1) !== C_CFG1) begin errors++; $display("FAIL cfg1_cmd: got %h exp %h", at16(wrt_cmd_q, 1), C_CFG1); end
        checks++; if (ati(wrt_cyc_q, 1) - ati(wrt_cyc_q, 0) !== BUSY + 1) begin errors++; $display("FAIL cfg1_spacing: got %0d exp %0d", ati(wrt_cyc_q, 1) - ati(wrt_cyc_q, 0), BUSY + 1); end
        checks++; if (cfg_rdy_cyc - ati(done_cyc_q, 1) !== 1) begin errors++; $display("FAIL cfg_rdy_latency: got %0d exp 1", cfg_rdy_cyc - ati(done_cyc_q, 1)); end
    endtask

    task automatic test_single_read();
        int n0, v0, dlast;
        n0 = wrt_cmd_q.size();
        v0 = vld_meas_q.size();
        force_en = 1;
        force_hi = 8'h12;
        force_lo = 8'h34;
        pulse_int();
        for (int i = 0; i < 300 && vld_meas_q.size() <= v0; i++) @(negedge clk);
        dlast = ati(done_cyc_q, done_cyc_q.size() - 1);
        checks++; if (vld_meas_q.size() <= v0) begin errors++; $display("FAIL read_timeout: vld count got %0d exp %0d", vld_meas_q.size(), v0 + 1); end
        checks++; if (at16(wrt_cmd_q, n0) !== C_RDHI) begin errors++; $display("FAIL read_hi_cmd: got %h exp %h", at16(wrt_cmd_q, n0), C_RDHI); end
        checks++; if (at16(wrt_cmd_q, n0 + 1) !== C_RDLO) begin errors++; $display("FAIL read_lo_cmd: got %h exp %h", at16(wrt_cmd_q, n0 + 1), C_RDLO); end
        checks++; if (at16(vld_meas_q, v0) !== 16'h1234) begin errors++; $display("FAIL read_meas: got %h exp 1234", at16(vld_meas_q, v0)); end
        checks++; if (ati(vld_cyc_q, v0) - dlast !== 1) begin errors++; $display("FAIL read_latency: got %0d exp 1", ati(vld_cyc_q, v0) - dlast); end
        repeat (20) @(negedge clk);
        checks++; if (meas !== 16'h1234) begin errors++; $display("FAIL read_meas_hold: got %h exp 1234", meas); end
        checks++; if (vld !== 1'b0) begin errors++; $display("FAIL read_vld_low: got %b exp 0", vld); end
        checks++; if (vld_meas_q.size() !== v0 + 1) begin errors++; $display("FAIL read_vld_count: got %0d exp %0d", vld_meas_q.size(), v0 + 1); end
        checks++; if (wrt_cmd_q.size() !== n0 + 2) begin errors++; $display("FAIL read_wrt_count: got %0d exp %0d", wrt_cmd_q.size(), n0 + 2); end
        force_en = 0;
    endtask

    task automatic test_back_to_back();
        int n0, v0, e0;
        n0 = wrt_cmd_q.size();
        v0 = vld_meas_q.size();
        e0 = exp_meas_q.size();
        pulse_int();
        for (int i = 0; i < 50 && wrt_cmd_q.size() <= n0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        pulse_int();
        pulse_int();
        for (int i = 0; i < 400 && vld_meas_q.size() < v0 + 2; i++) @(negedge clk);
        repeat (150) @(negedge clk);
        checks++; if (vld_meas_q.size() !== v0 + 2) begin errors++; $display("FAIL b2b_vld_count: got %0d exp %0d", vld_meas_q.size(), v0 + 2); end
        checks++; if (wrt_cmd_q.size() !== n0 + 4) begin errors++; $display("FAIL b2b_wrt_count: got %0d exp %0d", wrt_cmd_q.size(), n0 + 4); end
        checks++; if (at16(wrt_cmd_q, n0 + 2) !== C_RDHI) begin errors++; $display("FAIL b2b_hi_cmd: got %h exp %h", at16(wrt_cmd_q, n0 + 2), C_RDHI); end
        checks++; if (at16(wrt_cmd_q, n0 + 3) !== C_RDLO) begin errors++; $display("FAIL b2b_lo_cmd: got %h exp %h", at16(wrt_cmd_q, n0 + 3), C_RDLO); end
        checks++; if (ati(wrt_cyc_q, n0 + 2) - ati(vld_cyc_q, v0) !== 1) begin errors++; $display("FAIL b2b_gap: got %0d exp 1", ati(wrt_cyc_q, n0 + 2) - ati(vld_cyc_q, v0)); end
        checks++; if (at16(vld_meas_q, v0) !== at16(exp_meas_q, e0)) begin errors++; $display("FAIL b2b_meas0: got %h exp %h", at16(vld_meas_q, v0), at16(exp_meas_q, e0)); end
        checks++; if (at16(vld_meas_q, v0 + 1) !== at16(exp_meas_q, e0 + 1)) begin errors++; $display("FAIL b2b_meas1: got %h exp %h", at16(vld_meas_q, v0 + 1), at16(exp_meas_q, e0 + 1)); end
    endtask

    task automatic test_reset_mid_read();
        int n0;
        n0 = wrt_cmd_q.size();
        pulse_int();
        for (int i = 0; i < 200 && wrt_cmd_q.size() < n0 + 2; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        checks++; if (at16(wrt_cmd_q, n0 + 1) !== C_RDLO) begin errors++; $display("FAIL rst_setup_lo: got %h exp %h", at16(wrt_cmd_q, n0 + 1), C_RDLO); end
        rst_n = 1'b0;
        #1;
        checks++; if (meas !== 16'h0000) begin errors++; $display("FAIL rst_meas: got %h exp 0000", meas); end
        checks++; if (cfg_rdy !== 1'b0) begin errors++; $display("FAIL rst_cfg_rdy: got %b exp 0", cfg_rdy); end
        checks++; if (vld !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b exp 0", vld); end
        checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL rst_cmd: got %h exp 0000", cmd); end
        repeat (3) @(negedge clk);
        wrt_cmd_q.delete();
        wrt_cyc_q.delete();
        vld_meas_q.delete();
        vld_cyc_q.delete();
        exp_meas_q.delete();
        done_cyc_q.delete();
        cfg_rdy_cyc = -1;
        rst_n   = 1'b1;
        rel_cyc = cyc;
        repeat (2) @(negedge clk);
        pulse_int();
        for (int i = 0; i < 300 && wrt_cmd_q.size() < 3; i++) @(negedge clk);
        checks++; if (wrt_cmd_q.size() < 3) begin errors++; $display("FAIL early_timeout: wrt count got %0d exp 3", wrt_cmd_q.size()); end
        checks++; if (at16(wrt_cmd_q, 0) !== C_CFG0) begin errors++; $display("FAIL rst_cfg0_cmd: got %h exp %h", at16(wrt_cmd_q, 0), C_CFG0); end
        checks++; if (ati(wrt_cyc_q, 0) - rel_cyc !== 8) begin errors++; $display("FAIL rst_cfg0_delay: got %0d exp 8", ati(wrt_cyc_q, 0) - rel_cyc); end
        checks++; if (at16(wrt_cmd_q, 1) !== C_CFG1) begin errors++; $display("FAIL rst_cfg1_cmd: got %h exp %h", at16(wrt_cmd_q, 1), C_CFG1); end
        checks++; if (at16(wrt_cmd_q, 2) !== C_RDHI) begin errors++; $display("FAIL early_hi_cmd: got %h exp %h", at16(wrt_cmd_q, 2), C_RDHI); end
        checks++; if (ati(wrt_cyc_q, 2) - cfg_rdy_cyc !== 1) begin errors++; $display("FAIL early_hi_gap: got %0d exp 1", ati(wrt_cyc_q, 2) - cfg_rdy_cyc); end
        for (int i = 0; i < 200 && vld_meas_q.size() < 1; i++) @(negedge clk);
        checks++; if (at16(vld_meas_q, 0) !== at16(exp_meas_q, 0)) begin errors++; $display("FAIL early_meas: got %h exp %h", at16(vld_meas_q, 0), at16(exp_meas_q, 0)); end
        repeat (5) @(negedge clk);
        checks++; if (proto_err !== 0) begin errors++; $display("FAIL protocol: violations got %0d exp 0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_config();
        test_single_read();
        test_back_to_back();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
